// File: rtl/div_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : div_rs_if
// Description : Bundles the dispatch, CDB, divider-issue and status signals of
//               the divide reservation station.
//               slave  - seen by the station (div_rs)
//               master - seen by the environment (rename/dispatch, CDB,
//                        divider, writeback)
// Revision    : 1.0 - initial release
// ============================================================================
interface div_rs_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    // dispatch
    logic             disp_valid;
    logic             disp_ready;
    logic             disp_div;
    logic             disp_src1_rdy;
    logic [XLEN-1:0]  disp_src1_val;
    logic [TAG_W-1:0] disp_src1_tag;
    logic             disp_src2_rdy;
    logic [XLEN-1:0]  disp_src2_val;
    logic [TAG_W-1:0] disp_src2_tag;
    logic [TAG_W-1:0] disp_dest_tag;
    // common data bus
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    // divider issue
    logic             fu_ready;
    logic             fu_valid;
    logic             fu_div;
    logic [XLEN-1:0]  fu_dividend;
    logic [XLEN-1:0]  fu_divisor;
    // status
    logic [TAG_W-1:0] inflight_tag;
    logic             inflight_valid;
    logic [CW-1:0]    count;

    modport slave (
        input  flush, disp_valid, disp_div,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag, disp_dest_tag,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        output disp_ready, fu_valid, fu_div, fu_dividend, fu_divisor,
               inflight_tag, inflight_valid, count
    );

    modport master (
        output flush, disp_valid, disp_div,
               disp_src1_rdy, disp_src1_val, disp_src1_tag,
               disp_src2_rdy, disp_src2_val, disp_src2_tag, disp_dest_tag,
               cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  disp_ready, fu_valid, fu_div, fu_dividend, fu_divisor,
               inflight_tag, inflight_valid, count
    );
endinterface
`default_nettype wire

// File: rtl/div_rs.sv
`default_nettype none
// ============================================================================
// Module      : div_rs
// Description : Reservation station in front of the integer divider.
//               Collapsing queue (entry 0 oldest); operands are captured from
//               the CDB; the oldest ready entry is issued over fu_valid /
//               fu_ready; the dest tag of the last issued op is held in
//               inflight_tag for writeback.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-low reset
//               bus   - div_rs_if.slave (flush, dispatch, CDB, issue, status)
// Config      : DIV_RS_BYPASS_EN defined   - a dispatched source waiting on
//                                            a same-cycle CDB tag is written
//                                            ready with cdb_data.
//               DIV_RS_BYPASS_EN undefined - dispatch is stalled whenever
//                                            cdb_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module div_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    div_rs_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);

    // ---------------- entry storage ----------------
    logic             r_div    [DEPTH];
    logic             r_s1_rdy [DEPTH];
    logic [XLEN-1:0]  r_s1_val [DEPTH];
    logic [TAG_W-1:0] r_s1_tag [DEPTH];
    logic             r_s2_rdy [DEPTH];
    logic [XLEN-1:0]  r_s2_val [DEPTH];
    logic [TAG_W-1:0] r_s2_tag [DEPTH];
    logic [TAG_W-1:0] r_dest   [DEPTH];
    logic [CW-1:0]    r_count;
    logic [TAG_W-1:0] r_infl_tag;
    logic             r_infl_v;

    // entries after this cycle's CDB wakeup, in their old slots
    logic             w_wk_s1_rdy [DEPTH];
    logic [XLEN-1:0]  w_wk_s1_val [DEPTH];
    logic             w_wk_s2_rdy [DEPTH];
    logic [XLEN-1:0]  w_wk_s2_val [DEPTH];

    // next-state entries
    logic             w_n_div    [DEPTH];
    logic             w_n_s1_rdy [DEPTH];
    logic [XLEN-1:0]  w_n_s1_val [DEPTH];
    logic [TAG_W-1:0] w_n_s1_tag [DEPTH];
    logic             w_n_s2_rdy [DEPTH];
    logic [XLEN-1:0]  w_n_s2_val [DEPTH];
    logic [TAG_W-1:0] w_n_s2_tag [DEPTH];
    logic [TAG_W-1:0] w_n_dest   [DEPTH];

    logic             w_any;
    logic [SW-1:0]    w_sel;
    logic             w_issue;
    logic             w_space;
    logic             w_disp_ready;
    logic             w_disp;
    logic [CW-1:0]    w_wr_idx;
    logic [CW-1:0]    w_n_count;
    logic             w_new_s1_rdy;
    logic [XLEN-1:0]  w_new_s1_val;
    logic             w_new_s2_rdy;
    logic [XLEN-1:0]  w_new_s2_val;

    // Oldest ready entry. Uses registered readiness only, so an entry woken
    // by the CDB this cycle becomes issuable next cycle.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((i < int'(r_count)) && r_s1_rdy[i] && r_s2_rdy[i]) begin
                w_any = 1'b1;
                w_sel = SW'(i);
            end
        end
    end

    assign w_issue      = w_any & ~bus.flush & bus.fu_ready;
    assign w_space      = (r_count < CW'(DEPTH));
`ifdef DIV_RS_BYPASS_EN
    assign w_disp_ready = w_space | w_issue;
`else
    // A broadcast during dispatch could be missed between rename and the
    // station write, so dispatch simply waits it out.
    assign w_disp_ready = (w_space | w_issue) & ~bus.cdb_valid;
`endif
    assign w_disp       = bus.disp_valid & w_disp_ready & ~bus.flush;
    assign w_wr_idx     = w_issue ? (r_count - CW'(1)) : r_count;

    always_comb begin
        w_n_count = r_count;
        if (w_disp && !w_issue)      w_n_count = r_count + CW'(1);
        else if (!w_disp && w_issue) w_n_count = r_count - CW'(1);
    end

    // Source values for the incoming entry
    always_comb begin
        w_new_s1_rdy = bus.disp_src1_rdy;
        w_new_s1_val = bus.disp_src1_val;
        w_new_s2_rdy = bus.disp_src2_rdy;
        w_new_s2_val = bus.disp_src2_val;
`ifdef DIV_RS_BYPASS_EN
        if (bus.cdb_valid && !bus.disp_src1_rdy && (bus.disp_src1_tag == bus.cdb_tag)) begin
            w_new_s1_rdy = 1'b1;
            w_new_s1_val = bus.cdb_data;
        end
        if (bus.cdb_valid && !bus.disp_src2_rdy && (bus.disp_src2_tag == bus.cdb_tag)) begin
            w_new_s2_rdy = 1'b1;
            w_new_s2_val = bus.cdb_data;
        end
`endif
    end

    // CDB wakeup; both sources of an entry may match the same broadcast
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wk_s1_rdy[i] = r_s1_rdy[i];
            w_wk_s1_val[i] = r_s1_val[i];
            w_wk_s2_rdy[i] = r_s2_rdy[i];
            w_wk_s2_val[i] = r_s2_val[i];
            if (bus.cdb_valid && !r_s1_rdy[i] && (r_s1_tag[i] == bus.cdb_tag)) begin
                w_wk_s1_rdy[i] = 1'b1;
                w_wk_s1_val[i] = bus.cdb_data;
            end
            if (bus.cdb_valid && !r_s2_rdy[i] && (r_s2_tag[i] == bus.cdb_tag)) begin
                w_wk_s2_rdy[i] = 1'b1;
                w_wk_s2_val[i] = bus.cdb_data;
            end
        end
    end

    // Collapse: slots at or above the issued one take the (woken) contents
    // of the slot above; the dispatch lands on the first free slot after
    // the collapse.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            int k;
            k = j;
            if (w_issue && (j >= int'(w_sel)) && (j < DEPTH - 1)) k = j + 1;
            w_n_div[j]    = r_div[k];
            w_n_s1_rdy[j] = w_wk_s1_rdy[k];
            w_n_s1_val[j] = w_wk_s1_val[k];
            w_n_s1_tag[j] = r_s1_tag[k];
            w_n_s2_rdy[j] = w_wk_s2_rdy[k];
            w_n_s2_val[j] = w_wk_s2_val[k];
            w_n_s2_tag[j] = r_s2_tag[k];
            w_n_dest[j]   = r_dest[k];
            if (w_disp && (j == int'(w_wr_idx))) begin
                w_n_div[j]    = bus.disp_div;
                w_n_s1_rdy[j] = w_new_s1_rdy;
                w_n_s1_val[j] = w_new_s1_val;
                w_n_s1_tag[j] = bus.disp_src1_tag;
                w_n_s2_rdy[j] = w_new_s2_rdy;
                w_n_s2_val[j] = w_new_s2_val;
                w_n_s2_tag[j] = bus.disp_src2_tag;
                w_n_dest[j]   = bus.disp_dest_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_infl_tag <= '0;
            r_infl_v   <= 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                r_div[j]    <= 1'b0;
                r_s1_rdy[j] <= 1'b0;
                r_s1_val[j] <= '0;
                r_s1_tag[j] <= '0;
                r_s2_rdy[j] <= 1'b0;
                r_s2_val[j] <= '0;
                r_s2_tag[j] <= '0;
                r_dest[j]   <= '0;
            end
        end else begin
            // Validity is carried by r_count alone, so slot contents may be
            // updated unconditionally (also under flush).
            for (int j = 0; j < DEPTH; j++) begin
                r_div[j]    <= w_n_div[j];
                r_s1_rdy[j] <= w_n_s1_rdy[j];
                r_s1_val[j] <= w_n_s1_val[j];
                r_s1_tag[j] <= w_n_s1_tag[j];
                r_s2_rdy[j] <= w_n_s2_rdy[j];
                r_s2_val[j] <= w_n_s2_val[j];
                r_s2_tag[j] <= w_n_s2_tag[j];
                r_dest[j]   <= w_n_dest[j];
            end
            if (bus.flush) begin
                r_count  <= '0;
                r_infl_v <= 1'b0;
            end else begin
                r_count <= w_n_count;
                if (w_issue) begin
                    r_infl_tag <= r_dest[w_sel];
                    r_infl_v   <= 1'b1;
                end else if (bus.fu_ready) begin
                    // divider idle with nothing new: previous op has retired
                    r_infl_v <= 1'b0;
                end
            end
        end
    end

    assign bus.disp_ready     = w_disp_ready;
    assign bus.fu_valid       = w_any & ~bus.flush;
    assign bus.fu_div         = r_div[w_sel];
    assign bus.fu_dividend    = r_s1_val[w_sel];
    assign bus.fu_divisor     = r_s2_val[w_sel];
    assign bus.inflight_tag   = r_infl_tag;
    assign bus.inflight_valid = r_infl_v;
    assign bus.count          = r_count;
endmodule
`default_nettype wire
